queue_2x81_ctrl: RTL

- Two-entry ready/valid FIFO controller; direct upstream driver of the 2x81 register-file macro, which it uses as its storage.
- Owns enqueue/dequeue pointers and full/empty tracking; generates the macro's write (W0_*) and read (R0_*) port signals.
- Returns macro read data as deq_bits.
- Sits between a producer (e.g. a decode or issue lane) and a consumer that each hold a 81-bit payload.

---
 rtl/queue_2x81_ctrl.sv | 59 +++++
 1 files changed

// File: rtl/queue_2x81_ctrl.sv
// queue_2x81_ctrl: two-entry ready/valid FIFO controller driving a 2x81 register-file macro.
// Define QUEUE_PIPE_EN to let a full queue accept while it is being dequeued.
module queue_2x81_ctrl #(
  parameter int WIDTH = 81
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits,
  output logic [1:0]       count,
  output logic             R0_addr,
  output logic             R0_en,
  output logic             R0_clk,
  input  logic [WIDTH-1:0] R0_data,
  output logic             W0_addr,
  output logic             W0_en,
  output logic             W0_clk,
  output logic [WIDTH-1:0] W0_data
);
  logic enq_ptr, deq_ptr, maybe_full;
  logic ptr_match, empty, full, do_enq, do_deq;
  always_comb begin
    ptr_match = enq_ptr == deq_ptr;
    empty     = ptr_match & ~maybe_full;
    full      = ptr_match & maybe_full;
`ifdef QUEUE_PIPE_EN
    enq_ready = ~full | deq_ready;
`else
    enq_ready = ~full;
`endif
    deq_valid = ~empty;
    do_enq    = enq_valid & enq_ready;
    do_deq    = deq_valid & deq_ready;
    count     = full ? 2'd2 : {1'b0, enq_ptr ^ deq_ptr};
  end
  assign deq_bits = R0_data;
  assign R0_addr  = deq_ptr;
  assign R0_en    = 1'b1;
  assign R0_clk   = clock;
  assign W0_addr  = enq_ptr;
  assign W0_en    = do_enq;
  assign W0_clk   = clock;
  assign W0_data  = enq_bits;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enq_ptr    <= 1'b0;
      deq_ptr    <= 1'b0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq) enq_ptr <= ~enq_ptr;
      if (do_deq) deq_ptr <= ~deq_ptr;
      if (do_enq != do_deq) maybe_full <= do_enq;
    end
  end
endmodule
